// File: rtl/sdp_ram_gen.sv
// Simple dual-port RAM: byte-lane writes, 1/2-cycle registered reads, sequential post-reset clear.
// Optional per-lane even parity with fault injection when SDP_RAM_GEN_PARITY_EN is defined.
module sdp_ram_gen #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          WR_FIRST   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         rd_valid,
    output logic                         init_busy
`ifdef SDP_RAM_GEN_PARITY_EN
    ,
    input  logic                         wr_par_flip,
    output logic                         rd_perr
`endif
);
    localparam int unsigned NB     = DATA_WIDTH / BYTE_W;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [MEM_AW-1:0]     ptr_q, ptr_d;
    logic                  init_busy_q, init_busy_d;
    logic                  pipe_valid_q, pipe_valid_d;
    logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_in_range_c, rd_in_range_c;
    logic [MEM_AW-1:0]     wr_idx_c, rd_idx_c;
    logic                  wr_ok_c, rd_ok_c, collide_c;
    logic                  mem_we_c;
    logic [MEM_AW-1:0]     mem_waddr_c;
    logic [NB-1:0]         mem_be_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic [DATA_WIDTH-1:0] rd_word_c, fin_data_c;
    logic                  fin_valid_c;

    // Request qualification: requests only count in RUN and never alongside reset
    always_comb begin
        wr_in_range_c = 32'(wr_addr) < DEPTH;
        rd_in_range_c = 32'(rd_addr) < DEPTH;
        wr_idx_c      = wr_in_range_c ? MEM_AW'(wr_addr) : '0;
        rd_idx_c      = rd_in_range_c ? MEM_AW'(rd_addr) : '0;
        wr_ok_c       = !rst && (state_q == ST_RUN) && wr_en && wr_in_range_c;
        rd_ok_c       = !rst && (state_q == ST_RUN) && rd_en;
        collide_c     = wr_ok_c && rd_ok_c && (wr_addr == rd_addr);
    end

    // Clear/run sequencing and memory write-port selection
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_busy_d = init_busy_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_idx_c;
        mem_be_c    = wr_be;
        mem_wdata_c = data_in;
        case (state_q)
            ST_INIT: begin
                mem_we_c    = !rst;
                mem_waddr_c = ptr_q;
                mem_be_c    = '1;
                mem_wdata_c = '0;
                ptr_d       = ptr_q + MEM_AW'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_busy_d = 1'b0;
                end
            end
            ST_RUN:  mem_we_c = wr_ok_c;
            default: state_d  = ST_INIT;
        endcase
    end

    // Read path: optional new-data bypass on collision, then 1 or 2 register stages
    always_comb begin
        rd_word_c = rd_in_range_c ? mem_q[rd_idx_c] : '0;
        if (WR_FIRST && collide_c) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (wr_be[k]) rd_word_c[k*BYTE_W +: BYTE_W] = data_in[k*BYTE_W +: BYTE_W];
            end
        end
        pipe_valid_d = rd_ok_c;
        pipe_data_d  = rd_ok_c ? rd_word_c : pipe_data_q;
        if (RD_LATENCY == 2) begin
            fin_valid_c = pipe_valid_q;
            fin_data_c  = pipe_data_q;
        end else begin
            fin_valid_c = rd_ok_c;
            fin_data_c  = rd_word_c;
        end
        rd_valid_d = fin_valid_c;
        data_out_d = fin_valid_c ? fin_data_c : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            init_busy_q  <= 1'b1;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            rd_valid_q   <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            init_busy_q  <= init_busy_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            rd_valid_q   <= rd_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (mem_be_c[k]) mem_q[mem_waddr_c][k*BYTE_W +: BYTE_W] <= mem_wdata_c[k*BYTE_W +: BYTE_W];
            end
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = init_busy_q;

`ifdef SDP_RAM_GEN_PARITY_EN
    logic [NB-1:0] mem_par_q [DEPTH];
    logic [NB-1:0] wpar_c, rpar_c, stored_par_c;
    logic          s0_perr_c, fin_perr_c;
    logic          pipe_perr_q, pipe_perr_d;
    logic          rd_perr_q, rd_perr_d;

    // Parity generated on the write data, checked against the word actually returned
    always_comb begin
        wpar_c = '0;
        rpar_c = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            wpar_c[k] = (^mem_wdata_c[k*BYTE_W +: BYTE_W]) ^ (wr_ok_c & wr_par_flip);
            rpar_c[k] = ^rd_word_c[k*BYTE_W +: BYTE_W];
        end
        stored_par_c = mem_par_q[rd_idx_c];
        if (WR_FIRST && collide_c) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (wr_be[k]) stored_par_c[k] = wpar_c[k];
            end
        end
        s0_perr_c   = rd_in_range_c && (rpar_c != stored_par_c);
        pipe_perr_d = rd_ok_c && s0_perr_c;
        fin_perr_c  = (RD_LATENCY == 2) ? pipe_perr_q : s0_perr_c;
        rd_perr_d   = fin_valid_c && fin_perr_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_perr_q <= 1'b0;
            rd_perr_q   <= 1'b0;
        end else begin
            pipe_perr_q <= pipe_perr_d;
            rd_perr_q   <= rd_perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (mem_be_c[k]) mem_par_q[mem_waddr_c][k] <= wpar_c[k];
            end
        end
    end

    assign rd_perr = rd_perr_q;
`endif

endmodule

// File: tb/tb_sdp_ram_gen.sv
// Bench for sdp_ram_gen: two instances (16 deep/latency 1/new-data, 12 deep/latency 2/old-data)
// share one stimulus stream; a reference model queues expected reads with their due cycle.
module tb_sdp_ram_gen;
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        perr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [4:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] data_in;
    logic [31:0] data_out_a, data_out_b;
    logic        rd_valid_a, rd_valid_b, init_busy_a, init_busy_b;
`ifdef SDP_RAM_GEN_PARITY_EN
    logic        wr_par_flip, rd_perr_a, rd_perr_b;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          rst_d1 = 1'b0;
    bit          busy_known = 1'b0;
    logic [31:0] mdl_mem  [2][32];
    logic [3:0]  mdl_flip [2][32];
    int          busy_left [2];
    int          depth_m [2] = '{16, 12};
    int          lat_m   [2] = '{1, 2};
    bit          wrf_m   [2] = '{1'b1, 1'b0};
    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] last_a, last_b;

    always #5 clk = ~clk;

    sdp_ram_gen #(.DATA_WIDTH(32), .BYTE_W(8), .ADDR_WIDTH(5), .DEPTH(16),
                  .RD_LATENCY(1), .WR_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out_a),
        .rd_valid(rd_valid_a), .init_busy(init_busy_a)
`ifdef SDP_RAM_GEN_PARITY_EN
        , .wr_par_flip(wr_par_flip), .rd_perr(rd_perr_a)
`endif
    );

    sdp_ram_gen #(.DATA_WIDTH(32), .BYTE_W(8), .ADDR_WIDTH(4), .DEPTH(12),
                  .RD_LATENCY(2), .WR_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_be(wr_be),
        .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr[3:0]), .data_out(data_out_b),
        .rd_valid(rd_valid_b), .init_busy(init_busy_b)
`ifdef SDP_RAM_GEN_PARITY_EN
        , .wr_par_flip(wr_par_flip), .rd_perr(rd_perr_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model for instance i; ops are ignored while its clear is running
    task automatic mdl_step(input int i, input logic r, input logic we, input logic [4:0] wa_in,
                            input logic [3:0] be, input logic [31:0] wd, input logic re,
                            input logic [4:0] ra_in, input logic fl);
        int          wa, ra;
        exp_t        e;
        logic [31:0] w;
        logic [3:0]  f;
        wa = (i == 0) ? int'(wa_in) : int'(wa_in[3:0]);
        ra = (i == 0) ? int'(ra_in) : int'(ra_in[3:0]);
        if (r) begin
            busy_left[i] = depth_m[i];
            for (int a = 0; a < 32; a++) begin
                mdl_mem[i][a]  = '0;
                mdl_flip[i][a] = '0;
            end
        end else if (busy_left[i] > 0) begin
            busy_left[i]--;
        end else begin
            if (re) begin
                w = '0;
                f = '0;
                if (ra < depth_m[i]) begin
                    w = mdl_mem[i][ra];
                    f = mdl_flip[i][ra];
                    if (wrf_m[i] && we && wa == ra) begin
                        for (int k = 0; k < 4; k++) begin
                            if (be[k]) begin
                                w[k*8 +: 8] = wd[k*8 +: 8];
                                f[k]        = fl;
                            end
                        end
                    end
                end
                e.due  = cyc + lat_m[i];
                e.data = w;
                e.perr = |f;
                if (i == 0) q_a.push_back(e);
                else        q_b.push_back(e);
            end
            if (we && wa < depth_m[i]) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) begin
                        mdl_mem[i][wa][k*8 +: 8] = wd[k*8 +: 8];
                        mdl_flip[i][wa][k]       = fl;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic re, input logic [4:0] ra, input logic fl);
        rst     = r;
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        data_in = wd;
        rd_en   = re;
        rd_addr = ra;
`ifdef SDP_RAM_GEN_PARITY_EN
        wr_par_flip = fl;
`endif
        if (!r && busy_known) begin
            check("a_busy", 32'(init_busy_a), 32'(busy_left[0] > 0));
            check("b_busy", 32'(init_busy_b), 32'(busy_left[1] > 0));
        end
        if (r) busy_known = 1'b1;
        mdl_step(0, r, we, wa, be, wd, re, ra, fl);
        mdl_step(1, r, we, wa, be, wd, re, ra, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d, input logic fl);
        step(1'b0, 1'b1, a, be, d, 1'b0, 5'd0, fl);
    endtask

    task automatic rd(input logic [4:0] a);
        step(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, a, 1'b0);
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst_d1 <= rst;
        if (rst) mon_en <= 1'b1;
    end

    // Output monitor: a read result is due exactly on its cycle, otherwise outputs hold
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst_d1) begin
                last_a = '0;
                last_b = '0;
            end
            if (q_a.size() > 0 && q_a[0].due == cyc) begin
                e = q_a.pop_front();
                check("a_valid", 32'(rd_valid_a), 32'd1);
                check("a_data", data_out_a, e.data);
`ifdef SDP_RAM_GEN_PARITY_EN
                check("a_perr", 32'(rd_perr_a), 32'(e.perr));
`endif
                last_a = e.data;
            end else begin
                check("a_idle_valid", 32'(rd_valid_a), 32'd0);
                check("a_hold", data_out_a, last_a);
            end
            if (q_b.size() > 0 && q_b[0].due == cyc) begin
                e = q_b.pop_front();
                check("b_valid", 32'(rd_valid_b), 32'd1);
                check("b_data", data_out_b, e.data);
`ifdef SDP_RAM_GEN_PARITY_EN
                check("b_perr", 32'(rd_perr_b), 32'(e.perr));
`endif
                last_b = e.data;
            end else begin
                check("b_idle_valid", 32'(rd_valid_b), 32'd0);
                check("b_hold", data_out_b, last_b);
            end
        end
    end

    initial begin
        logic        we, re, fl;
        logic [4:0]  wa, ra;
        logic [3:0]  be;
        logic [31:0] wd;

        step(1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 5'd1, 4'hF, 32'h5555_5555, 1'b1, 5'd1, 1'b0);
        check("rst_data_a", data_out_a, 32'h0);
        check("rst_valid_a", 32'(rd_valid_a), 32'd0);
        check("rst_busy_a", 32'(init_busy_a), 32'd1);
        check("rst_data_b", data_out_b, 32'h0);
        check("rst_valid_b", 32'(rd_valid_b), 32'd0);
        check("rst_busy_b", 32'(init_busy_b), 32'd1);

        // reads issued all through the clear, then every address read once after it
        for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(i % 16), 1'b0);
        idle(3);

        wr(5'd5, 4'hF, 32'hAABB_CCDD, 1'b0);
        wr(5'd5, 4'h5, 32'h1122_3344, 1'b0);
        rd(5'd5);
        wr(5'd5, 4'h0, 32'hFFFF_FFFF, 1'b0);
        rd(5'd5);
        idle(3);

        step(1'b0, 1'b1, 5'd3, 4'hF, 32'hDEAD_BEEF, 1'b1, 5'd3, 1'b0);
        idle(3);
        rd(5'd3);
        idle(3);

        for (int i = 0; i < 8; i++) wr(5'(i), 4'hF, 32'(i) * 32'h0101_0101, 1'b0);
        for (int i = 0; i < 8; i++) rd(5'(i));
        idle(4);

        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            fl = 1'($urandom_range(0, 1));
            step(1'b0, we, wa, be, wd, re, ra, fl);
        end
        idle(3);

        wr(5'd13, 4'hF, 32'hCAFE_F00D, 1'b0);
        rd(5'd13);
        wr(5'd20, 4'hF, 32'h0BAD_BEEF, 1'b0);
        rd(5'd20);
        idle(3);

        wr(5'd2, 4'hF, 32'h1234_5678, 1'b1);
        rd(5'd2);
        wr(5'd2, 4'hF, 32'h1234_5678, 1'b0);
        rd(5'd2);
        idle(3);

        // reset again part-way through the clear; busy must restart from the new release
        step(1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 9; i++) rd(5'(i));
        step(1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 18; i++) rd(5'd5);
        idle(4);

        check("drain_a", 32'(q_a.size()), 32'd0);
        check("drain_b", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
